rx_iq_decim: RTL and testbench

RX_IQ_DECIM -- requirements
Module: rx_iq_decim

---
 rtl/sdr_pkg.sv | 7 +
 rtl/rx_decim_chan.sv | 34 +++
 rtl/rx_iq_decim.sv | 58 +++++
 tb/tb_rx_iq_decim.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// sdr_pkg: sample/IQ widths shared by the RX decimator, the AFE and the FIFO glue
package sdr_pkg;
    localparam int SAMPLE_WIDTH   = 12;
    localparam int IQ_PAIR_WIDTH  = 2 * SAMPLE_WIDTH;
    localparam int MAX_RATIO_LOG2 = 4;
    localparam int ACC_WIDTH      = SAMPLE_WIDTH + MAX_RATIO_LOG2;
endpackage

// File: rtl/rx_decim_chan.sv
// rx_decim_chan: one I or Q channel of the block-average decimator
module rx_decim_chan
    import sdr_pkg::*;
#(
    parameter int SW = SAMPLE_WIDTH,
    parameter int MR = MAX_RATIO_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [SW-1:0] sample,
    input  logic                 in_valid,
    input  logic                 last,
    input  logic [2:0]           r,
    output logic signed [SW-1:0] result
);
    localparam int AW = SW + MR;
    localparam logic signed [AW:0] MAX_V = (AW+1)'((1 << (SW - 1)) - 1);
    localparam logic signed [AW:0] MIN_V = -MAX_V - (AW+1)'(1);
    logic signed [AW-1:0] acc, sum;
    logic [AW:0] half;
    logic signed [AW:0] rnd, sh;
    assign sum  = acc + {{MR{sample[SW-1]}}, sample};
    assign half = (r == 3'd0) ? '0 : (AW+1)'(1) << (r - 3'd1);
    // one extra bit keeps the rounding add from wrapping at full scale
    assign rnd  = {sum[AW-1], sum} + $signed(half);
    assign sh   = rnd >>> r;
    assign result = (sh > MAX_V) ? MAX_V[SW-1:0] : (sh < MIN_V) ? MIN_V[SW-1:0] : sh[SW-1:0];
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (in_valid)
            acc <= last ? '0 : sum;
    end
endmodule

// File: rtl/rx_iq_decim.sv
// rx_iq_decim: power-of-two IQ decimator feeding the a2f FIFO, dropping on full
module rx_iq_decim
    import sdr_pkg::*;
#(
    parameter int IQ_PAIR_WIDTH  = sdr_pkg::IQ_PAIR_WIDTH,
    parameter int SAMPLE_WIDTH   = sdr_pkg::SAMPLE_WIDTH,
    parameter int MAX_RATIO_LOG2 = sdr_pkg::MAX_RATIO_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IQ_PAIR_WIDTH-1:0] in_data,
    input  logic                     in_valid,
    input  logic [2:0]               ratio_log2,
    input  logic                     fifo_full_i,
    output logic [IQ_PAIR_WIDTH-1:0] out_data,
    output logic                     out_wr,
    output logic [15:0]              drop_cnt
);
    localparam int MR = MAX_RATIO_LOG2;
    logic [MR-1:0] phase;
    logic [MR:0] mask;
    logic [2:0] r_q, r_lim, r_cur;
    logic last;
    logic [SAMPLE_WIDTH-1:0] i_res, q_res;
    assign r_lim = (ratio_log2 > 3'(MR)) ? 3'(MR) : ratio_log2;
    // a new block picks up the ratio at its first sample; later samples use the latched one
    assign r_cur = (phase == '0) ? r_lim : r_q;
    assign mask  = ((MR+1)'(1) << r_cur) - (MR+1)'(1);
    assign last  = in_valid && ({1'b0, phase} == mask);
    rx_decim_chan #(.SW(SAMPLE_WIDTH), .MR(MR)) u_i (
        .clk(clk), .rst(rst), .sample(in_data[SAMPLE_WIDTH-1:0]), .in_valid(in_valid),
        .last(last), .r(r_cur), .result(i_res)
    );
    rx_decim_chan #(.SW(SAMPLE_WIDTH), .MR(MR)) u_q (
        .clk(clk), .rst(rst), .sample(in_data[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]), .in_valid(in_valid),
        .last(last), .r(r_cur), .result(q_res)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            r_q      <= '0;
            out_wr   <= 1'b0;
            out_data <= '0;
            drop_cnt <= '0;
        end else begin
            out_wr <= last && !fifo_full_i;
            if (in_valid) begin
                phase <= last ? '0 : phase + 1'b1;
                if (phase == '0)
                    r_q <= r_lim;
            end
            if (last && !fifo_full_i)
                out_data <= {q_res, i_res};
            if (last && fifo_full_i && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_rx_iq_decim.sv
// tb_rx_iq_decim: directed vectors with a queue scoreboard checking data and exact latency
module tb_rx_iq_decim;
    typedef struct {
        logic [23:0] d;
        int          cyc;
    } exp_t;
    logic clk = 0, rst = 1, in_valid = 0, fifo_full_i = 0, out_wr;
    logic [23:0] in_data = 0, out_data;
    logic [2:0] ratio_log2 = 0;
    logic [15:0] drop_cnt;
    int total = 0, bad = 0, cyc = 0;
    exp_t sb[$];

    rx_iq_decim dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .ratio_log2(ratio_log2),
        .fifo_full_i(fifo_full_i), .out_data(out_data), .out_wr(out_wr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_wr) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_wr cyc=%0d got=%h required=no write", cyc, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_data !== e.d || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL out_pair got=%h@%0d required=%h@%0d", out_data, cyc, e.d, e.cyc);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            total++;
            bad++;
            $display("FAIL missing_wr cyc=%0d required=%h@%0d", cyc, sb[0].d, sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    task automatic check16(input string name, input logic [23:0] got, input logic [23:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic send(input int i, input int q, input bit e, input int ei, input int eq);
        @(negedge clk);
        in_valid = 1;
        in_data = {q[11:0], i[11:0]};
        if (e) begin
            exp_t x;
            x.d = {eq[11:0], ei[11:0]};
            x.cyc = cyc + 1;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 0;
        end
    endtask

    initial begin
        in_valid = 1;
        in_data = 24'h123456;
        repeat (3) @(negedge clk);
        rst = 0;
        in_valid = 0;
        check16("rst_out_wr", {23'd0, out_wr}, 24'd0);
        check16("rst_out_data", out_data, 24'd0);
        check16("rst_drop_cnt", {8'd0, drop_cnt}, 24'd0);
        // passthrough
        ratio_log2 = 0;
        for (int k = 0; k < 5; k++) send(5, -7, 1, 5, -7);
        send(-2048, 2047, 1, -2048, 2047);
        idle(3);
        check16("hold_data", out_data, 24'h7FF800);
        // rounding r=2
        ratio_log2 = 2;
        send(1, 0, 0, 0, 0); send(2, 0, 0, 0, 0); send(2, 0, 0, 0, 0); send(1, 0, 1, 2, 0);
        idle(2);
        send(-1, 3, 0, 0, 0); send(-1, 3, 0, 0, 0); send(-1, 3, 0, 0, 0); send(-2, 3, 1, -1, 3);
        idle(2);
        // saturation r=1
        ratio_log2 = 1;
        send(2047, 1, 0, 0, 0); send(2047, 2, 1, 2047, 2);
        send(-2048, -2048, 0, 0, 0); send(-2048, -2048, 1, -2048, -2048);
        idle(2);
        // fifo full r=3
        ratio_log2 = 3;
        fifo_full_i = 1;
        for (int k = 0; k < 24; k++) send(k, -k, 0, 0, 0);
        idle(1);
        fifo_full_i = 0;
        check16("drop_cnt_3", {8'd0, drop_cnt}, 24'd3);
        idle(1);
        // ratio change mid-block, then clamp of 7 to 4
        ratio_log2 = 2;
        send(4, 4, 0, 0, 0); send(4, 4, 0, 0, 0);
        ratio_log2 = 4;
        send(4, 4, 0, 0, 0); send(4, 4, 1, 4, 4);
        for (int k = 0; k < 16; k++) send(1, -1, k == 15, 1, -1);
        ratio_log2 = 7;
        for (int k = 0; k < 16; k++) send(-3, 100, k == 15, -3, 100);
        idle(2);
        // reset mid-block
        ratio_log2 = 3;
        for (int k = 0; k < 5; k++) send(50, 50, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        in_valid = 1;
        in_data = 24'h7FF7FF;
        @(negedge clk);
        rst = 0;
        in_valid = 0;
        check16("rst_mid_wr", {23'd0, out_wr}, 24'd0);
        for (int k = 0; k < 8; k++) send(2, -1, k == 7, 2, -1);
        idle(2);
        check16("rst_mid_drop", {8'd0, drop_cnt}, 24'd0);
        // drop counter saturation at full throughput
        ratio_log2 = 0;
        fifo_full_i = 1;
        @(negedge clk);
        in_valid = 1;
        in_data = 24'h001001;
        repeat (65540) @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        check16("drop_cnt_sat", {8'd0, drop_cnt}, 24'h00FFFF);
        fifo_full_i = 0;
        idle(3);
        check16("sb_empty", 24'(sb.size()), 24'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
